// File: rtl/des_round_sequencer.sv
// DES round sequencer: holds L/R and C/D state, walks 16 rounds against an external
// f-function, and applies IP/FP/PC1/PC2 as fixed bit routing.
module des_round_sequencer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Decrypt,
    input  logic [63:0] DataIn,
    input  logic [63:0] KeyIn,
    output logic [31:0] FRight,
    output logic [47:0] FKey,
    input  logic [31:0] FResult,
    output logic        Busy,
    output logic        Done,
    output logic [63:0] DataOut
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

    localparam int unsigned FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Bit i set where the key schedule shifts by 2 in round i, otherwise by 1.
    localparam logic [15:0] SHIFT_TWO = 16'h7EFC;

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned i = 0; i < 64; i++) y[63 - i] = x[64 - IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned i = 0; i < 64; i++) y[63 - i] = x[64 - FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int unsigned i = 0; i < 56; i++) y[55 - i] = x[64 - PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int unsigned i = 0; i < 48; i++) y[47 - i] = x[56 - PC2_T[i]];
        return y;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  round_q;
    logic        mode_q;
    logic [3:0]  shift_idx;
    logic        shift_two;
    logic [55:0] cd_n;
    logic        unused_parity;

    assign unused_parity = ^{KeyIn[56], KeyIn[48], KeyIn[40], KeyIn[32],
                             KeyIn[24], KeyIn[16], KeyIn[8], KeyIn[0]};

    // Decrypt walks the schedule backwards: round r undoes shift S[16-r], i.e. index -r mod 16.
    always_comb begin
        shift_idx = mode_q ? (4'd0 - round_q) : round_q;
        shift_two = SHIFT_TWO[shift_idx];
        cd_n      = {c_q, d_q};
        if (!mode_q) begin
            cd_n = {rotl28(c_q, shift_two), rotl28(d_q, shift_two)};
        end else if (round_q != 4'd0) begin
            cd_n = {rotr28(c_q, shift_two), rotr28(d_q, shift_two)};
        end
    end

    always_comb begin
        FKey   = '0;
        FRight = '0;
        if (state_q == ROUND) begin
            FKey   = pc2_perm(cd_n);
            FRight = r_q;
        end
    end

    assign Busy = (state_q != IDLE);
    assign Done = (state_q == DONE);

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = ROUND;
            ROUND:   if (round_q == 4'd15) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
            DataOut <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        {l_q, r_q} <= ip_perm(DataIn);
                        {c_q, d_q} <= pc1_perm(KeyIn);
                        mode_q     <= Decrypt;
                        round_q    <= '0;
                    end
                end
                ROUND: begin
                    if (round_q == 4'd15) begin
                        DataOut <= fp_perm({l_q ^ FResult, r_q});
                    end else begin
                        {c_q, d_q} <= cd_n;
                        l_q        <= r_q;
                        r_q        <= l_q ^ FResult;
                        round_q    <= round_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench for des_round_sequencer; supplies a reference DES f-function on
// FResult and checks known FIPS vectors, timing, reset abort and back-to-back use.
module tb_des_round_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Decrypt;
    logic [63:0] DataIn;
    logic [63:0] KeyIn;
    logic [31:0] FRight;
    logic [47:0] FKey;
    logic [31:0] FResult;
    logic        Busy;
    logic        Done;
    logic [63:0] DataOut;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] KEY   = 64'h133457799BBCDFF1;
    localparam logic [63:0] PLAIN = 64'h0123456789ABCDEF;
    localparam logic [63:0] CIPH  = 64'h85E813540F0AB405;
    localparam logic [47:0] K1    = 48'h1B02EFFC7072;
    localparam logic [47:0] K16   = 48'hCB3D8B0E17F5;

    des_round_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Decrypt(Decrypt),
        .DataIn(DataIn), .KeyIn(KeyIn), .FRight(FRight), .FKey(FKey),
        .FResult(FResult), .Busy(Busy), .Done(Done), .DataOut(DataOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        int          v;
        e = '0;
        s = '0;
        y = '0;
        for (int i = 0; i < 48; i++) e[47 - i] = r[32 - E_T[i]];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            b = e[47 - 6 * j -: 6];
            v = SBOX[j][{b[5], b[0]} * 16 + int'(b[4:1])];
            s[31 - 4 * j -: 4] = v[3:0];
        end
        for (int i = 0; i < 32; i++) y[31 - i] = s[32 - P_T[i]];
        return y;
    endfunction

    always_comb FResult = f_model(FRight, FKey);

    // Issues one Start, then samples 24 cycles starting with ROUND cycle 0.
    task automatic run_block(input logic [63:0] key, input logic [63:0] data, input logic dec,
                             input logic [63:0] prev_dout,
                             output int done_at, output int done_cnt, output int busy_cnt,
                             output logic [47:0] fk0, output logic [47:0] fk15,
                             output logic [31:0] fr0, output logic [63:0] result,
                             output logic dout_held);
        Start = 1'b1; Decrypt = dec; KeyIn = key; DataIn = data;
        @(posedge Clk); #1;
        Start = 1'b0; DataIn = 64'hFFFF0000FFFF0000;
        done_at = -1; done_cnt = 0; busy_cnt = 0;
        fk0 = '0; fk15 = '0; fr0 = '0; result = '0; dout_held = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k == 0) begin fk0 = FKey; fr0 = FRight; end
            if (k == 15) fk15 = FKey;
            if (Busy) busy_cnt++;
            if (Done) begin
                done_cnt++;
                if (done_at < 0) begin done_at = k; result = DataOut; end
            end else if (done_at < 0 && DataOut !== prev_dout) begin
                dout_held = 1'b0;
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; Start = 1'b1; Decrypt = 1'b0; KeyIn = KEY; DataIn = PLAIN;
        repeat (3) @(posedge Clk);
        #1;
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", Done); end
        n_checks++; if (FKey !== 48'h0) begin n_fail++; $display("FAIL reset_fkey: got %h expected 0", FKey); end
        n_checks++; if (FRight !== 32'h0) begin n_fail++; $display("FAIL reset_fright: got %h expected 0", FRight); end
        n_checks++; if (DataOut !== 64'h0) begin n_fail++; $display("FAIL reset_dataout: got %h expected 0", DataOut); end
        Reset = 1'b0; Start = 1'b0;
        @(posedge Clk); #1;
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", Busy); end
    endtask

    task automatic test_encrypt;
        int d_at, d_cnt, b_cnt;
        logic [47:0] fk0, fk15;
        logic [31:0] fr0;
        logic [63:0] res;
        logic held;
        run_block(KEY, PLAIN, 1'b0, 64'h0, d_at, d_cnt, b_cnt, fk0, fk15, fr0, res, held);
        n_checks++; if (d_at !== 16) begin n_fail++; $display("FAIL enc_done_cycle: got %0d expected 16", d_at); end
        n_checks++; if (d_cnt !== 1) begin n_fail++; $display("FAIL enc_done_count: got %0d expected 1", d_cnt); end
        n_checks++; if (b_cnt !== 17) begin n_fail++; $display("FAIL enc_busy_cycles: got %0d expected 17", b_cnt); end
        n_checks++; if (res !== CIPH) begin n_fail++; $display("FAIL enc_result: got %h expected %h", res, CIPH); end
        n_checks++; if (fk0 !== K1) begin n_fail++; $display("FAIL enc_fkey_r0: got %h expected %h", fk0, K1); end
        n_checks++; if (fk15 !== K16) begin n_fail++; $display("FAIL enc_fkey_r15: got %h expected %h", fk15, K16); end
        n_checks++; if (fr0 !== 32'hF0AAF0AA) begin n_fail++; $display("FAIL enc_fright_r0: got %h expected f0aaf0aa", fr0); end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL enc_dataout_held: got %b expected 1", held); end
        n_checks++; if (FKey !== 48'h0) begin n_fail++; $display("FAIL enc_idle_fkey: got %h expected 0", FKey); end
        n_checks++; if (FRight !== 32'h0) begin n_fail++; $display("FAIL enc_idle_fright: got %h expected 0", FRight); end
        n_checks++; if (DataOut !== CIPH) begin n_fail++; $display("FAIL enc_dataout_hold: got %h expected %h", DataOut, CIPH); end
    endtask

    task automatic test_decrypt;
        int d_at, d_cnt, b_cnt;
        logic [47:0] fk0, fk15;
        logic [31:0] fr0;
        logic [63:0] res;
        logic held;
        run_block(KEY, CIPH, 1'b1, CIPH, d_at, d_cnt, b_cnt, fk0, fk15, fr0, res, held);
        n_checks++; if (d_at !== 16) begin n_fail++; $display("FAIL dec_done_cycle: got %0d expected 16", d_at); end
        n_checks++; if (res !== PLAIN) begin n_fail++; $display("FAIL dec_result: got %h expected %h", res, PLAIN); end
        n_checks++; if (fk0 !== K16) begin n_fail++; $display("FAIL dec_fkey_r0: got %h expected %h", fk0, K16); end
        n_checks++; if (fk15 !== K1) begin n_fail++; $display("FAIL dec_fkey_r15: got %h expected %h", fk15, K1); end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL dec_dataout_held: got %b expected 1", held); end
    endtask

    // Start stays high; DataIn is scrambled mid-block but valid at every accepting edge.
    task automatic test_start_held;
        int done_k [3];
        int n_done;
        n_done = 0;
        Start = 1'b1; Decrypt = 1'b0; KeyIn = KEY; DataIn = PLAIN;
        @(posedge Clk); #1;
        for (int k = 0; k < 54; k++) begin
            if (Done) begin
                if (n_done < 3) done_k[n_done] = k;
                n_done++;
                n_checks++; if (DataOut !== CIPH) begin n_fail++; $display("FAIL held_result: got %h expected %h at cycle %0d", DataOut, CIPH, k); end
            end
            if ((k % 18) >= 2 && (k % 18) <= 12) DataIn = {$urandom(), $urandom()};
            else DataIn = PLAIN;
            @(posedge Clk); #1;
        end
        Start = 1'b0;
        n_checks++; if (n_done !== 3) begin n_fail++; $display("FAIL held_done_count: got %0d expected 3", n_done); end
        if (n_done == 3) begin
            n_checks++; if (done_k[0] !== 16) begin n_fail++; $display("FAIL held_first_done: got %0d expected 16", done_k[0]); end
            n_checks++; if (done_k[1] - done_k[0] !== 18) begin n_fail++; $display("FAIL held_period1: got %0d expected 18", done_k[1] - done_k[0]); end
            n_checks++; if (done_k[2] - done_k[1] !== 18) begin n_fail++; $display("FAIL held_period2: got %0d expected 18", done_k[2] - done_k[1]); end
        end
        repeat (20) @(posedge Clk);
        #1;
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL held_final_idle: got %b expected 0", Busy); end
    endtask

    task automatic test_reset_abort;
        int d_at, d_cnt, b_cnt, stray;
        logic [47:0] fk0, fk15;
        logic [31:0] fr0;
        logic [63:0] res;
        logic held;
        Start = 1'b1; Decrypt = 1'b0; KeyIn = KEY; DataIn = PLAIN;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (7) @(posedge Clk);
        #1;
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_r7: got %b expected 1", Busy); end
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", Busy); end
        n_checks++; if (DataOut !== 64'h0) begin n_fail++; $display("FAIL abort_dataout: got %h expected 0", DataOut); end
        n_checks++; if (FKey !== 48'h0) begin n_fail++; $display("FAIL abort_fkey: got %h expected 0", FKey); end
        stray = 0;
        for (int k = 0; k < 25; k++) begin
            if (Done) stray++;
            @(posedge Clk); #1;
        end
        n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", stray); end
        run_block(KEY, PLAIN, 1'b0, 64'h0, d_at, d_cnt, b_cnt, fk0, fk15, fr0, res, held);
        n_checks++; if (d_at !== 16) begin n_fail++; $display("FAIL abort_rerun_cycle: got %0d expected 16", d_at); end
        n_checks++; if (res !== CIPH) begin n_fail++; $display("FAIL abort_rerun_result: got %h expected %h", res, CIPH); end
    endtask

    // Decrypt then encrypt, second Start raised during DONE and held into the following IDLE edge.
    task automatic test_back_to_back;
        int done2;
        logic held;
        done2 = -1; held = 1'b1;
        Start = 1'b1; Decrypt = 1'b1; KeyIn = KEY; DataIn = CIPH;
        @(posedge Clk); #1;
        Start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 16) begin
                n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b expected 1", Done); end
                n_checks++; if (DataOut !== PLAIN) begin n_fail++; $display("FAIL b2b_first_result: got %h expected %h", DataOut, PLAIN); end
                Start = 1'b1; Decrypt = 1'b0; DataIn = PLAIN;
            end
            if (k == 17) begin
                n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got %b expected 0", Busy); end
            end
            if (k == 18) begin
                Start = 1'b0; DataIn = '0;
                n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accepted: got %b expected 1", Busy); end
            end
            if (k > 16 && Done && done2 < 0) begin
                done2 = k;
                n_checks++; if (DataOut !== CIPH) begin n_fail++; $display("FAIL b2b_second_result: got %h expected %h", DataOut, CIPH); end
            end else if (k > 16 && done2 < 0 && DataOut !== PLAIN) begin
                held = 1'b0;
            end
            @(posedge Clk); #1;
        end
        n_checks++; if (done2 !== 34) begin n_fail++; $display("FAIL b2b_second_cycle: got %0d expected 34", done2); end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL b2b_dataout_held: got %b expected 1", held); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; Decrypt = 1'b0; DataIn = '0; KeyIn = '0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_start_held();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
